// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus sequencer.
package rtc_bus_pkg;

    localparam int unsigned BusWidth = 8;

    // Strobe and address/data-select levels while the bus is parked
    localparam logic CsNIdle = 1'b1;
    localparam logic RdNIdle = 1'b1;
    localparam logic WrNIdle = 1'b1;
    localparam logic ADIdle  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StALow,
        StAHigh,
        StGap,
        StDLow,
        StDHigh,
        StDone
    } state_e;

    typedef struct packed {
        logic                cs_n;
        logic                rd_n;
        logic                wr_n;
        logic                a_d;
        logic                ad_oe;
        logic [BusWidth-1:0] ad_out;
    } bus_t;

    localparam bus_t IdleBus = '{
        cs_n:   CsNIdle,
        rd_n:   RdNIdle,
        wr_n:   WrNIdle,
        a_d:    ADIdle,
        ad_oe:  1'b0,
        ad_out: '0
    };

    // Bus pin levels to hold for the whole of a given state
    function automatic bus_t bus_levels(input state_e st, input logic wr,
                                        input logic [BusWidth-1:0] addr,
                                        input logic [BusWidth-1:0] wdata);
        bus_t b;
        b = IdleBus;
        case (st)
            StALow: begin
                b.cs_n   = 1'b0;
                b.wr_n   = 1'b0;
                b.a_d    = 1'b0;
                b.ad_oe  = 1'b1;
                b.ad_out = addr;
            end
            StAHigh: begin
                b.a_d    = 1'b0;
                b.ad_oe  = 1'b1;
                b.ad_out = addr;
            end
            StGap, StDHigh: begin
                b.ad_oe  = wr;
                b.ad_out = wr ? wdata : '0;
            end
            StDLow: begin
                b.cs_n = 1'b0;
                if (wr) begin
                    b.wr_n   = 1'b0;
                    b.ad_oe  = 1'b1;
                    b.ad_out = wdata;
                end else begin
                    b.rd_n = 1'b0;
                end
            end
            default: b = IdleBus;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Request/response and RTC pad signals of the bus sequencer.
interface rtc_bus_sequencer_if;
    import rtc_bus_pkg::*;

    logic                start;
    logic                wr;
    logic [BusWidth-1:0] addr;
    logic [BusWidth-1:0] wdata;
    logic [BusWidth-1:0] ad_in;
    logic [BusWidth-1:0] ad_out;
    logic                ad_oe;
    logic                a_d;
    logic                cs_n;
    logic                rd_n;
    logic                wr_n;
    logic                busy;
    logic                done;
    logic [BusWidth-1:0] rdata;

    // Control FSM and pads side
    modport master (
        output start, wr, addr, wdata, ad_in,
        input  ad_out, ad_oe, a_d, cs_n, rd_n, wr_n, busy, done, rdata
    );

    // Sequencer side
    modport slave (
        input  start, wr, addr, wdata, ad_in,
        output ad_out, ad_oe, a_d, cs_n, rd_n, wr_n, busy, done, rdata
    );

endinterface

// File: rtl/rtc_phase_timer.sv
// Phase-length counter; flags the final cycle of each bus phase.
module rtc_phase_timer #(
    parameter int unsigned PHASE_CYC = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic last
);

    localparam int unsigned CntW = $clog2(PHASE_CYC);

    logic [CntW-1:0] count;

    // Count up from zero; restart reloads so every phase starts at zero
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == CntW'(PHASE_CYC - 1));

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Drives one RTC read or write over the multiplexed address/data bus.
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int unsigned PHASE_CYC = 10
) (
    input  logic          clock,
    input  logic          reset,
    rtc_bus_sequencer_if.slave bus
);

    state_e              state;
    bus_t                lv;
    logic                txn_wr;
    logic [BusWidth-1:0] txn_addr;
    logic [BusWidth-1:0] txn_wdata;
    logic [BusWidth-1:0] rdata_r;
    logic                busy_r;
    logic                done_r;
    logic                last;
    logic                restart;

    // Hold the timer at zero while parked; reload on every phase change
    assign restart = (state == StIdle) || (state == StDone) || last;

    rtc_phase_timer #(
        .PHASE_CYC (PHASE_CYC)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .restart (restart),
        .last    (last)
    );

    // Phase sequencing; pin levels are registered alongside the state change
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= StIdle;
            lv        <= IdleBus;
            txn_wr    <= 1'b0;
            txn_addr  <= '0;
            txn_wdata <= '0;
            rdata_r   <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                StIdle: begin
                    if (bus.start) begin
                        txn_wr    <= bus.wr;
                        txn_addr  <= bus.addr;
                        txn_wdata <= bus.wdata;
                        state     <= StALow;
                        lv        <= bus_levels(StALow, bus.wr, bus.addr, bus.wdata);
                        busy_r    <= 1'b1;
                    end
                end
                StALow: begin
                    if (last) begin
                        state <= StAHigh;
                        lv    <= bus_levels(StAHigh, txn_wr, txn_addr, txn_wdata);
                    end
                end
                StAHigh: begin
                    if (last) begin
                        state <= StGap;
                        lv    <= bus_levels(StGap, txn_wr, txn_addr, txn_wdata);
                    end
                end
                StGap: begin
                    if (last) begin
                        state <= StDLow;
                        lv    <= bus_levels(StDLow, txn_wr, txn_addr, txn_wdata);
                    end
                end
                StDLow: begin
                    if (last) begin
                        // Capture while rd_n is still low
                        if (!txn_wr) begin
                            rdata_r <= bus.ad_in;
                        end
                        state <= StDHigh;
                        lv    <= bus_levels(StDHigh, txn_wr, txn_addr, txn_wdata);
                    end
                end
                StDHigh: begin
                    if (last) begin
                        state  <= StDone;
                        lv     <= IdleBus;
                        done_r <= 1'b1;
                    end
                end
                StDone: begin
                    state  <= StIdle;
                    busy_r <= 1'b0;
                end
                default: begin
                    state  <= StIdle;
                    lv     <= IdleBus;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cs_n   = lv.cs_n;
    assign bus.rd_n   = lv.rd_n;
    assign bus.wr_n   = lv.wr_n;
    assign bus.a_d    = lv.a_d;
    assign bus.ad_oe  = lv.ad_oe;
    assign bus.ad_out = lv.ad_out;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.rdata  = rdata_r;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed checks of rtc_bus_sequencer at P=4 plus random protocol runs at P=2 and P=10.
module tb_rtc_bus_sequencer;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;
    logic [7:0] rd_model;

    rtc_bus_sequencer_if bif ();

    rtc_bus_sequencer #(
        .PHASE_CYC (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ctl"}, 32'({bif.cs_n, bif.rd_n, bif.wr_n, bif.a_d, bif.ad_oe,
                                  bif.busy, bif.done}), 32'(7'b1111000));
        check({tag, "_ad_out"}, 32'(bif.ad_out), 32'h00);
        check({tag, "_rdata"}, 32'(bif.rdata), 32'(rd_model));
    endtask

    // Caller is in the cycle where start is raised (cycle 0); returns in cycle 21.
    task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] rdv, input bit poke, input int abort_at);
        int   dones;
        int   ph;
        bit   aborted;
        bit   chk_out;
        logic e_cs, e_rd, e_wr, e_ad, e_oe, e_busy, e_done;
        logic [7:0] e_out;
        dones     = 0;
        bif.wr    = w;
        bif.addr  = a;
        bif.wdata = d;
        bif.ad_in = 8'hAA;
        bif.start = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            tick();
            bif.start = poke && (c == 5 || c == 21);
            if (poke && c == 5) begin
                bif.wr    = ~w;
                bif.addr  = 8'hEE;
                bif.wdata = 8'hEE;
            end
            bif.ad_in = (c >= 13 && c <= 16) ? rdv : 8'hAA;
            reset     = (c == abort_at);
            aborted   = (abort_at != 0) && (c > abort_at);
            if (aborted && c == abort_at + 1) rd_model = 8'h00;
            if (!aborted && !w && c == 17) rd_model = rdv;

            {e_cs, e_rd, e_wr, e_ad, e_oe, e_busy, e_done} = 7'b1111000;
            e_out   = 8'h00;
            chk_out = 1'b1;
            if (!aborted) begin
                e_busy = 1'b1;
                if (c == 21) begin
                    e_done = 1'b1;
                end else begin
                    ph = (c - 1) / 4;
                    case (ph)
                        0: begin e_cs = 0; e_wr = 0; e_ad = 0; e_oe = 1; e_out = a; end
                        1: begin e_ad = 0; e_oe = 1; e_out = a; end
                        3: begin
                            e_cs = 0;
                            if (w) begin e_wr = 0; e_oe = 1; e_out = d; end
                            else begin e_rd = 0; chk_out = 1'b0; end
                        end
                        default: begin e_oe = w; e_out = d; chk_out = w; end
                    endcase
                end
            end
            dones += int'(bif.done);
            check($sformatf("c%0d_ctl", c),
                  32'({bif.cs_n, bif.rd_n, bif.wr_n, bif.a_d, bif.ad_oe, bif.busy, bif.done}),
                  32'({e_cs, e_rd, e_wr, e_ad, e_oe, e_busy, e_done}));
            if (chk_out) check($sformatf("c%0d_ad_out", c), 32'(bif.ad_out), 32'(e_out));
            check($sformatf("c%0d_rdata", c), 32'(bif.rdata), 32'(rd_model));
        end
        check("done_cnt", 32'(dones), (abort_at != 0) ? 32'd0 : 32'd1);
    endtask

    // Random back-to-back traffic with protocol checks at two phase lengths
    for (genvar gi = 0; gi < 2; gi++) begin : g_rnd
        localparam int unsigned P = (gi == 0) ? 2 : 10;
        logic rrst;
        bit   live;
        bit   fin;
        rtc_bus_sequencer_if rif ();

        rtc_bus_sequencer #(
            .PHASE_CYC (P)
        ) u_dut (
            .clock (clock),
            .reset (rrst),
            .bus   (rif)
        );

        initial begin
            int cnt;
            logic w;
            logic [7:0] a, d, v, exp_rd;
            fin       = 1'b0;
            live      = 1'b0;
            rrst      = 1'b1;
            rif.start = 1'b0;
            rif.wr    = 1'b0;
            rif.addr  = 8'h00;
            rif.wdata = 8'h00;
            rif.ad_in = 8'h00;
            exp_rd    = 8'h00;
            repeat (3) tick();
            rrst = 1'b0;
            live = 1'b1;
            for (int n = 0; n < 500; n++) begin
                w         = 1'($urandom_range(0, 1));
                a         = 8'($urandom);
                d         = 8'($urandom);
                v         = 8'($urandom);
                rif.wr    = w;
                rif.addr  = a;
                rif.wdata = d;
                rif.ad_in = v;
                rif.start = 1'b1;
                tick();
                rif.start = 1'b0;
                cnt = 1;
                while (rif.done !== 1'b1 && cnt < int'(6 * P + 5)) begin
                    tick();
                    cnt++;
                end
                check($sformatf("rnd_p%0d_lat", P), 32'(cnt), 32'(5 * P + 1));
                if (!w) exp_rd = v;
                check($sformatf("rnd_p%0d_rdata", P), 32'(rif.rdata), 32'(exp_rd));
                tick();
            end
            fin = 1'b1;
        end

        always @(negedge clock) begin
            if (live) begin
                check("proto_rd_wr", 32'(rif.rd_n | rif.wr_n), 32'd1);
                check("proto_oe_rd", 32'(!(rif.ad_oe && !rif.rd_n)), 32'd1);
                check("proto_cs", 32'(rif.cs_n || !rif.rd_n || !rif.wr_n), 32'd1);
            end
        end
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rd_model  = 8'h00;
        reset     = 1'b1;
        bif.start = 1'b0;
        bif.wr    = 1'b0;
        bif.addr  = 8'h00;
        bif.wdata = 8'h00;
        bif.ad_in = 8'h00;
        repeat (3) tick();
        check_idle("reset");
        reset = 1'b0;
        tick();
        check_idle("post_reset");

        // Write 0x45 to 0x21
        run_txn(1'b1, 8'h21, 8'h45, 8'h00, 1'b0, 0);
        tick();
        bif.start = 1'b0;
        check_idle("wr_c22");

        // Read 0x22, pads return 0x37
        run_txn(1'b0, 8'h22, 8'h00, 8'h37, 1'b0, 0);
        tick();
        bif.start = 1'b0;
        check_idle("rd_c22");

        // Stray starts at cycles 5 and 21, then a read started in cycle 22
        run_txn(1'b1, 8'h5A, 8'hC3, 8'h00, 1'b1, 0);
        tick();
        bif.start = 1'b0;
        check_idle("poke_c22");
        run_txn(1'b0, 8'h33, 8'h00, 8'h99, 1'b0, 0);
        tick();
        bif.start = 1'b0;
        check_idle("chain_c22");

        // Reset in cycle 14 of a write
        run_txn(1'b1, 8'h21, 8'h45, 8'h00, 1'b0, 14);
        tick();
        check_idle("abort_after");

        for (int i = 0; i < 60000; i++) begin
            if (g_rnd[0].fin && g_rnd[1].fin) break;
            tick();
        end
        check("rnd_finished", 32'({g_rnd[0].fin, g_rnd[1].fin}), 32'(2'b11));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Bus-side responder to the system control FSM. It receives a single-transaction request (read or write, one address byte, one data byte) and drives the RTC's multiplexed address/data bus with the phase timing the chip requires. The bus signals are a_d, cs_n, rd_n, wr_n and the shared AD[7:0]. It sits between the control block's data-extraction, save and initialisation strobes and the top-level tri-state AD pads, and returns `done` plus read data.

## Interface
- PHASE_CYC, 10: clock cycles per bus phase (10 = 100 ns at 100 MHz); legal range 2–255.
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request strobe; sampled only in IDLE.
- wr  in  1  1 = write transaction, 0 = read transaction; sampled with start.
- addr  in  8  RTC register address; sampled with start.
- wdata  in  8  write data; sampled with start.
- ad_in  in  8  AD bus value from the pads.
- ad_out  out  8  AD value to drive.
- ad_oe  out  1  1 = pads drive ad_out.
- a_d  out  1  0 = address phase, 1 = data phase.
- cs_n, rd_n, wr_n  out  1 each  active-low chip select, read and write strobes.
- busy  out  1  high from the first bus phase through the done cycle.
- done  out  1  one-cycle completion pulse.
- rdata  out  8  last read byte; held until the next completed read.

## Operation
- States: IDLE, A_LOW, A_HIGH, GAP, D_LOW, D_HIGH, DONE.
- Each state from A_LOW through D_HIGH lasts exactly PHASE_CYC cycles. DONE lasts 1 cycle and then returns to IDLE.
- IDLE: start=1 latches wr, addr and wdata, then moves to A_LOW. start outside IDLE, including during the DONE cycle, is ignored and is not queued.
- Per-state outputs:
  - IDLE and DONE: cs_n=rd_n=wr_n=1, a_d=1, ad_oe=0, ad_out=0x00.
  - A_LOW: cs_n=0, wr_n=0, a_d=0, ad_oe=1, ad_out=addr.
  - A_HIGH: cs_n=1, wr_n=1, a_d=0, ad_oe=1, ad_out=addr (address hold).
  - GAP: strobes high, a_d=1. For a write, ad_oe=1 and ad_out=wdata (data setup). For a read, ad_oe=0.
  - D_LOW, write: cs_n=0, wr_n=0, ad_oe=1, ad_out=wdata.
  - D_LOW, read: cs_n=0, rd_n=0, ad_oe=0.
  - D_HIGH: strobes high, a_d=1. For a write, ad_oe=1 with data held. For a read, ad_oe=0.
- rd_n and wr_n are never low in the same cycle. ad_oe is never 1 while rd_n=0.
- Read capture: rdata <= ad_in on the last cycle of D_LOW, while rd_n is still low. A write leaves rdata unchanged.
- done=1 only in DONE. busy=1 in every state except IDLE.

## Timing
- Start is sampled at edge k. A_LOW covers cycles k+1 to k+P. A_HIGH covers k+P+1 to k+2P. This continues until D_HIGH ends at k+5P.
- done is high in cycle k+5P+1. The earliest next accepted start is sampled at edge k+5P+2. With P=10: done at k+51, throughput one transaction per 52 cycles.
- All outputs are registered and glitch-free. Each strobe changes level only at phase boundaries.
- Reset values: cs_n=rd_n=wr_n=1, a_d=1, ad_oe=0, ad_out=0x00, busy=0, done=0, rdata=0x00, state IDLE, phase counter 0.
- Reset mid-transaction applies the reset values on the next edge. The transaction is aborted, no done is issued, and rdata is cleared.
- Phase counter width: $clog2(PHASE_CYC). It counts 0..PHASE_CYC-1 and reloads to 0 on every state change.

## Structure
- Package rtc_bus_pkg holds:
  - the state enum;
  - the idle-level constants for cs_n, rd_n, wr_n and a_d;
  - the bus width (8).
- Sub-module rtc_phase_timer holds the counter. Inputs: clock, reset, restart. Output: last, asserted on count PHASE_CYC-1. The FSM advances on `last`.

## Test plan
- Write, P=4, addr=0x21, wdata=0x45, start at edge 0:
  - cycles 1–4: ad_out=0x21, a_d=0, wr_n=0;
  - cycles 13–16: wr_n=0, ad_out=0x45;
  - done=1 in cycle 21;
  - rd_n stays 1 throughout.
- Read, P=4, addr=0x22, ad_in=0x37 during D_LOW: ad_oe=0 in cycles 9–20, rd_n=0 in cycles 13–16, rdata=0x37 from cycle 17, done in cycle 21.
- start pulses at cycles 5 and 21 during a busy transaction: both ignored, exactly one done pulse. A start at cycle 22 is accepted, with A_LOW beginning at cycle 23.
- Reset asserted in cycle 14 of a write: idle levels from cycle 15, no done pulse, busy=0.
- Protocol assertions over 1000 random read/write transactions with P in {2, 10}:
  - rd_n and wr_n never both 0;
  - ad_oe never 1 while rd_n=0;
  - cs_n=0 only in A_LOW or D_LOW.
